// File: rtl/mux_rr_sel.sv
// -----------------------------------------------------------------------------
// mux_rr_sel
//   N-channel, W-bit registered multiplexer with valid/ready handshakes on every
//   input and on the output. One channel is picked per cycle, either the one
//   named by sel_i (manual mode) or by fair round-robin arbitration (scan mode).
//   The chosen beat lands in a single output register tagged with its channel.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous active-low reset
//   in_data_i    CH*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid_i   per-channel valid
//   in_ready_o   per-channel accept (combinational, at most one bit high)
//   mode_i       0 = manual select, 1 = round-robin scan
//   sel_i        channel index used in manual mode
//   out_data_o   registered selected data
//   out_ch_o     registered index of the channel that supplied out_data_o
//   out_valid_o  registered output valid
//   out_ready_i  downstream accept
// -----------------------------------------------------------------------------
module mux_rr_sel #(
  parameter int WIDTH = 4,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [CH*WIDTH-1:0]   in_data_i,
  input  logic [CH-1:0]         in_valid_i,
  output logic [CH-1:0]         in_ready_o,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [SEL_W-1:0]      out_ch_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  // After reset the pointer sits on the last channel so the first scan starts at 0.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en_s;
  logic             grant_valid_s;
  logic [SEL_W-1:0] grant_s;
  logic [CH-1:0]    in_ready_s;

  // Channel index base+off wrapped modulo CH; off never exceeds CH, so a single
  // subtraction is enough.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= CH) begin
      sum = sum - CH;
    end else begin
      sum = sum;
    end
    return SEL_W'(sum);
  endfunction

  // The output register may take a new beat when empty or draining this cycle.
  assign load_en_s = !out_valid_q || out_ready_i;

  // Grant decision: manual select or round-robin search starting after ptr_q.
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    if (mode_i == 1'b0) begin
      // Out-of-range select values (CH not a power of two) never grant.
      if (int'(sel_i) < CH) begin
        if (in_valid_i[sel_i]) begin
          grant_s       = sel_i;
          grant_valid_s = 1'b1;
        end else begin
          grant_valid_s = 1'b0;
        end
      end else begin
        grant_valid_s = 1'b0;
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        if (!grant_valid_s && in_valid_i[wrap_idx(ptr_q, k)]) begin
          grant_s       = wrap_idx(ptr_q, k);
          grant_valid_s = 1'b1;
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  // Accept strobe for the granted channel. Held low during reset because a beat
  // accepted then would be discarded by the same reset edge.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < CH; i++) begin
      if (rst_ni && load_en_s && grant_valid_s && (grant_s == SEL_W'(i))) begin
        in_ready_s[i] = 1'b1;
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en_s) begin
      if (grant_valid_s) begin
        out_data_d  = in_data_i[grant_s*WIDTH +: WIDTH];
        out_ch_d    = grant_s;
        out_valid_d = 1'b1;
        ptr_d       = grant_s;
      end else begin
        // Nothing to load: drop valid, keep the last data/channel visible.
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= PTR_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_sel
//   Directed bench for mux_rr_sel (CH=4, WIDTH=4) with a distance-based
//   arbitration model compared on every falling edge, plus literal checks along
//   the directed sequence. A second CH=3 instance exercises the illegal select.
// -----------------------------------------------------------------------------
module tb_mux_rr_sel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [3:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mux_rr_sel #(.WIDTH(4), .CH(4), .SEL_W(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .mode_i(mode), .sel_i(sel), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  mux_rr_sel #(.WIDTH(4), .CH(3), .SEL_W(2)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data3), .in_valid_i(in_valid3),
    .in_ready_o(in_ready3), .mode_i(mode3), .sel_i(sel3), .out_data_o(out_data3),
    .out_ch_o(out_ch3), .out_valid_o(out_valid3), .out_ready_i(out_ready3)
  );

  // ---------------- behavioural model ----------------
  logic       m_valid;
  logic [3:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;
  int         m_grant;
  logic [3:0] m_ready;

  // Winner = valid channel with the smallest forward distance past the pointer.
  function automatic int pick(input logic [3:0] v, input logic md,
                              input logic [1:0] s, input int p);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 4;
    if (!md) begin
      if (v[s]) best = int'(s);
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (v[c]) begin
          d = (c - p - 1 + 8) % 4;
          if (d < bestd) begin
            bestd = d;
            best  = c;
          end
        end
      end
    end
    return best;
  endfunction

  always_comb m_grant = pick(in_valid, mode, sel, m_ptr);
  always_comb m_ready = (rst_n && (!m_valid || out_ready) && m_grant >= 0)
                        ? (4'b0001 << m_grant) : 4'b0000;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 4'h0;
      m_ch    <= 2'd0;
      m_ptr   <= 3;
    end else if (!m_valid || out_ready) begin
      if (m_grant >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[m_grant*4 +: 4];
        m_ch    <= m_grant[1:0];
        m_ptr   <= m_grant;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_out_data", 32'(out_data), 32'(m_data));
      check("cyc_out_ch", 32'(out_ch), 32'(m_ch));
      check("cyc_in_ready", 32'(in_ready), 32'(m_ready));
      check("cyc_ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
      if (sel3 == 2'd3) begin
        check("ch3_sel3_valid", 32'(out_valid3), 32'd0);
        check("ch3_sel3_ready", 32'(in_ready3), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [3:0] d,
                            input logic [1:0] c);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    check({name, "_data"}, 32'(out_data), 32'(d));
    check({name, "_ch"}, 32'(out_ch), 32'(c));
  endtask

  logic [3:0] chan_data [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [1:0] rr_seq    [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] skip_seq  [4] = '{2'd0, 2'd2, 2'd3, 2'd0};

  initial begin
    rst_n = 1'b0; in_data = 16'hDCBA; in_valid = 4'hF; mode = 1'b0; sel = 2'd0;
    out_ready = 1'b1;
    in_data3 = 12'h321; in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;

    // Reset held two cycles with every channel valid.
    tick();
    started = 1'b1;
    expect_out("rst1", 1'b0, 4'h0, 2'd0);
    check("rst1_ready", 32'(in_ready), 32'd0);
    tick();
    expect_out("rst2", 1'b0, 4'h0, 2'd0);
    check("rst2_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // Manual select stepping through every channel.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      expect_out("manual", 1'b1, chan_data[i], 2'(i));
    end

    // Round-robin fairness, then with channel 1 dropped.
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out("rr_all", 1'b1, chan_data[rr_seq[i]], rr_seq[i]);
    end
    in_valid = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("rr_skip1", 1'b1, chan_data[skip_seq[i]], skip_seq[i]);
    end

    // Backpressure with a held beat of 4'h5 from channel 2.
    in_data = 16'hD5BA;
    tick();
    expect_out("bp_load", 1'b1, 4'h5, 2'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("bp_hold", 1'b1, 4'h5, 2'd2);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    expect_out("bp_release", 1'b1, 4'hD, 2'd3);
    in_data = 16'hDCBA;

    // Manual select of an empty channel drains the register.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
    tick();
    expect_out("empty", 1'b0, 4'hD, 2'd3);
    check("empty_ready", 32'(in_ready), 32'd0);

    // Mode switching.
    in_valid = 4'hF; mode = 1'b1;
    tick();
    expect_out("sw_rr0", 1'b1, 4'hA, 2'd0);
    tick();
    expect_out("sw_rr1", 1'b1, 4'hB, 2'd1);
    mode = 1'b0; sel = 2'd3;
    tick();
    expect_out("sw_man3", 1'b1, 4'hD, 2'd3);
    mode = 1'b1;
    tick();
    expect_out("sw_back_rr", 1'b1, 4'hA, 2'd0);

    // Reset while a beat is held.
    rst_n = 1'b0;
    tick();
    expect_out("midrst", 1'b0, 4'h0, 2'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    expect_out("post_rst0", 1'b1, 4'hA, 2'd0);
    tick();
    expect_out("post_rst1", 1'b1, 4'hB, 2'd1);

    // CH=3 instance: a legal select does grant.
    sel3 = 2'd2;
    tick();
    check("ch3_sel2_valid", 32'(out_valid3), 32'd1);
    check("ch3_sel2_data", 32'(out_data3), 32'h3);
    check("ch3_sel2_ch", 32'(out_ch3), 32'd2);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
